conv_window_sequencer: RTL and testbench

- Parametrised successor to the fixed 112x112 window counter group.
- Tracks the 3x3 convolution window position over a pixel stream coming out of the line buffer. Produces a 9-bit per-tap enable mask, which applies zero-padding at the borders.
- Image size, channel count and padding mode are set at run time, latched on start. Also provides channel and layer bookkeeping.
- Sits between the line buffer and the multiplier bar. Its chnl_done output drives weight switching.

---
 rtl/conv_window_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_conv_window_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sequencer.sv
// 3x3 convolution window sequencer: tracks window centre over a line-buffer pixel
// stream, generates zero-padding tap enables and channel/layer completion strobes.
module conv_window_sequencer #(
  parameter int DIM_W = 8,
  parameter int CH_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic [CH_W-1:0]  cfg_chnl,
  input  logic             cfg_pad,
  input  logic             valid_i,
  output logic             busy,
  output logic             cfg_err,
  output logic             valid_o,
  output logic [8:0]       en_o,
  output logic [DIM_W-1:0] x_o,
  output logic [DIM_W-1:0] y_o,
  output logic [CH_W-1:0]  ch_o,
  output logic             chnl_done,
  output logic             layer_done
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [DIM_W-1:0] w_q, w_d, h_q, h_d;
  logic [CH_W-1:0]  c_q, c_d;
  logic             pad_q, pad_d;
  logic [DIM_W:0]   fill_q, fill_d;
  logic [DIM_W-1:0] x_q, x_d, y_q, y_d;
  logic [CH_W-1:0]  ch_q, ch_d;

  logic             valid_q, valid_d;
  logic             chnl_done_q, chnl_done_d;
  logic             layer_done_q, layer_done_d;
  logic             cfg_err_q, cfg_err_d;
  logic [8:0]       en_q, en_d;
  logic [DIM_W-1:0] xo_q, xo_d, yo_q, yo_d;
  logic [CH_W-1:0]  cho_q, cho_d;

  logic       cfg_ok;
  logic       x_first, x_last, y_first, y_last, ch_last, border;
  logic [8:0] tap_mask;

  assign cfg_ok  = (cfg_width >= DIM_W'(3)) && (cfg_height >= DIM_W'(3)) && (cfg_chnl != '0);
  assign x_first = (x_q == '0);
  assign x_last  = (x_q == w_q - DIM_W'(1));
  assign y_first = (y_q == '0);
  assign y_last  = (y_q == h_q - DIM_W'(1));
  assign ch_last = (ch_q == c_q - CH_W'(1));
  assign border  = x_first || x_last || y_first || y_last;

  // Rows are bits [2:0]/[5:3]/[8:6]; columns are every third bit.
  always_comb begin
    tap_mask = 9'h1FF;
    if (y_first) tap_mask[2:0] = 3'b000;
    if (y_last)  tap_mask[8:6] = 3'b000;
    if (x_first) tap_mask = tap_mask & 9'b110_110_110;
    if (x_last)  tap_mask = tap_mask & 9'b011_011_011;
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (which would infer a latch); the defaults hold state and clear the strobes.
    state_d      = state_q;
    w_d          = w_q;
    h_d          = h_q;
    c_d          = c_q;
    pad_d        = pad_q;
    fill_d       = fill_q;
    x_d          = x_q;
    y_d          = y_q;
    ch_d         = ch_q;
    valid_d      = 1'b0;
    chnl_done_d  = 1'b0;
    layer_done_d = 1'b0;
    cfg_err_d    = 1'b0;
    en_d         = en_q;
    xo_d         = xo_q;
    yo_d         = yo_q;
    cho_d        = cho_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            w_d     = cfg_width;
            h_d     = cfg_height;
            c_d     = cfg_chnl;
            pad_d   = cfg_pad;
            fill_d  = {1'b0, cfg_width} + (DIM_W+1)'(1);
            x_d     = '0;
            y_d     = '0;
            ch_d    = '0;
            state_d = S_FILL;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      // The line buffer needs one full row plus one pixel before the first
      // centre (0,0) has its lower-right neighbour available.
      S_FILL: begin
        if (valid_i) begin
          fill_d = fill_q - (DIM_W+1)'(1);
          if (fill_q == (DIM_W+1)'(1)) state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (valid_i) begin
          xo_d    = x_q;
          yo_d    = y_q;
          cho_d   = ch_q;
          en_d    = tap_mask;
          valid_d = pad_q || !border;
          if (x_last) begin
            x_d = '0;
            if (y_last) begin
              y_d         = '0;
              ch_d        = ch_q + CH_W'(1);
              chnl_done_d = 1'b1;
              if (ch_last) begin
                layer_done_d = 1'b1;
                ch_d         = '0;
                state_d      = S_IDLE;
              end
            end else begin
              y_d = y_q + DIM_W'(1);
            end
          end else begin
            x_d = x_q + DIM_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_q          <= '0;
      h_q          <= '0;
      c_q          <= '0;
      pad_q        <= 1'b0;
      fill_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      ch_q         <= '0;
      valid_q      <= 1'b0;
      chnl_done_q  <= 1'b0;
      layer_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      en_q         <= '0;
      xo_q         <= '0;
      yo_q         <= '0;
      cho_q        <= '0;
    end else begin
      w_q          <= w_d;
      h_q          <= h_d;
      c_q          <= c_d;
      pad_q        <= pad_d;
      fill_q       <= fill_d;
      x_q          <= x_d;
      y_q          <= y_d;
      ch_q         <= ch_d;
      valid_q      <= valid_d;
      chnl_done_q  <= chnl_done_d;
      layer_done_q <= layer_done_d;
      cfg_err_q    <= cfg_err_d;
      en_q         <= en_d;
      xo_q         <= xo_d;
      yo_q         <= yo_d;
      cho_q        <= cho_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign cfg_err    = cfg_err_q;
  assign valid_o    = valid_q;
  assign en_o       = en_q;
  assign x_o        = xo_q;
  assign y_o        = yo_q;
  assign ch_o       = cho_q;
  assign chnl_done  = chnl_done_q;
  assign layer_done = layer_done_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed self-checking bench for conv_window_sequencer: reset, padded/valid
// modes, stalls, configuration errors, start while busy and a wide image.
module tb_conv_window_sequencer;

  localparam int DIM_W = 8;
  localparam int CH_W  = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [DIM_W-1:0] cfg_width;
  logic [DIM_W-1:0] cfg_height;
  logic [CH_W-1:0]  cfg_chnl;
  logic             cfg_pad;
  logic             valid_i;
  logic             busy;
  logic             cfg_err;
  logic             valid_o;
  logic [8:0]       en_o;
  logic [DIM_W-1:0] x_o;
  logic [DIM_W-1:0] y_o;
  logic [CH_W-1:0]  ch_o;
  logic             chnl_done;
  logic             layer_done;

  int n_checks = 0;
  int n_err    = 0;
  logic [8:0] en_log [0:63];
  int nv;

  conv_window_sequencer #(.DIM_W(DIM_W), .CH_W(CH_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_chnl   (cfg_chnl),
    .cfg_pad    (cfg_pad),
    .valid_i    (valid_i),
    .busy       (busy),
    .cfg_err    (cfg_err),
    .valid_o    (valid_o),
    .en_o       (en_o),
    .x_o        (x_o),
    .y_o        (y_o),
    .ch_o       (ch_o),
    .chnl_done  (chnl_done),
    .layer_done (layer_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tap enables built tap by tap from the border rules.
  function automatic logic [8:0] exp_en(int x, int y, int w, int h);
    logic [8:0] m;
    m = 9'h1FF;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if ((r == 0 && y == 0) || (r == 2 && y == h - 1) ||
            (c == 0 && x == 0) || (c == 2 && x == w - 1))
          m[3*r+c] = 1'b0;
    return m;
  endfunction

  task automatic do_start(input int w, input int h, input int c, input bit pad);
    cfg_width  = DIM_W'(w);
    cfg_height = DIM_W'(h);
    cfg_chnl   = CH_W'(c);
    cfg_pad    = pad;
    start      = 1'b1;
    valid_i    = 1'b0;
    tick();
    start      = 1'b0;
  endtask

  // Full layer with per-beat checks; gap inserts an idle cycle after every beat,
  // poke pulses start (with other cfg values) during the third RUN beat.
  task automatic run_layer(input int w, input int h, input int c, input bit pad,
                           input bit gap, input bit poke, output int nvalid);
    int  x, y, ch, last;
    bit  vo;
    nvalid = 0;
    do_start(w, h, c, pad);
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < w + 1; i++) begin
      valid_i = 1'b1;
      tick();
      check("fill_no_valid", 32'(valid_o), 32'd0);
      check("fill_busy", 32'(busy), 32'd1);
      if (gap) begin
        valid_i = 1'b0;
        tick();
        check("fill_gap_no_valid", 32'(valid_o), 32'd0);
      end
    end
    last = w * h * c - 1;
    for (int k = 0; k <= last; k++) begin
      x  = k % w;
      y  = (k / w) % h;
      ch = k / (w * h);
      vo = pad || !(x == 0 || x == w - 1 || y == 0 || y == h - 1);
      valid_i = 1'b1;
      if (poke && k == 2) begin
        start     = 1'b1;
        cfg_width = 8'd7;
        cfg_chnl  = 8'd3;
      end
      tick();
      start = 1'b0;
      if (k < 64) en_log[k] = en_o;
      check("valid_o", 32'(valid_o), 32'(vo));
      check("x_o", 32'(x_o), 32'(x));
      check("y_o", 32'(y_o), 32'(y));
      check("ch_o", 32'(ch_o), 32'(ch));
      check("en_o", 32'(en_o), 32'(exp_en(x, y, w, h)));
      check("chnl_done", 32'(chnl_done), 32'(x == w - 1 && y == h - 1));
      check("layer_done", 32'(layer_done), 32'(k == last));
      check("busy_run", 32'(busy), 32'(k != last));
      if (valid_o) nvalid++;
      if (gap) begin
        valid_i = 1'b0;
        tick();
        check("gap_no_valid", 32'(valid_o), 32'd0);
        check("gap_no_chnl_done", 32'(chnl_done), 32'd0);
        check("gap_x_hold", 32'(x_o), 32'(x));
        check("gap_y_hold", 32'(y_o), 32'(y));
      end
    end
    valid_i = 1'b0;
    tick();
    check("post_layer_busy", 32'(busy), 32'd0);
    check("post_layer_valid", 32'(valid_o), 32'd0);
    check("post_layer_done", 32'(layer_done), 32'd0);
    check("post_layer_x_hold", 32'(x_o), 32'(w - 1));
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    cfg_width  = '0;
    cfg_height = '0;
    cfg_chnl   = '0;
    cfg_pad    = 1'b0;
    valid_i    = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_en", 32'(en_o), 32'd0);
    check("rst_xyc", 32'({x_o, y_o, ch_o}), 32'd0);
    check("rst_flags", 32'({cfg_err, chnl_done, layer_done}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic padded run: 4x4, 2 channels
    run_layer(4, 4, 2, 1'b1, 1'b0, 1'b0, nv);
    check("basic_nvalid", 32'(nv), 32'd32);
    check("basic_en_0_0", 32'(en_log[0]), 32'h1B0);
    check("basic_en_3_0", 32'(en_log[3]), 32'h0D8);
    check("basic_en_1_1", 32'(en_log[5]), 32'h1FF);
    check("basic_en_3_3", 32'(en_log[15]), 32'h01B);

    // Reset mid-RUN at valid beat 10 (5 fill + 4 run beats, then reset)
    do_start(4, 4, 2, 1'b1);
    valid_i = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    check("pre_abort_x", 32'(x_o), 32'd3);
    check("pre_abort_en", 32'(en_o), 32'h0D8);
    rst_n = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(valid_o), 32'd0);
    check("abort_en", 32'(en_o), 32'd0);
    check("abort_x", 32'(x_o), 32'd0);
    rst_n   = 1'b1;
    valid_i = 1'b0;
    tick();
    run_layer(4, 4, 2, 1'b1, 1'b0, 1'b0, nv);
    check("after_abort_nvalid", 32'(nv), 32'd32);
    check("after_abort_en_0_0", 32'(en_log[0]), 32'h1B0);

    // Valid mode: 5x4, 1 channel -> 3x2 interior windows
    run_layer(5, 4, 1, 1'b0, 1'b0, 1'b0, nv);
    check("validmode_nvalid", 32'(nv), 32'd6);

    // Stalls: 4x3, 1 channel, valid_i toggling
    run_layer(4, 3, 1, 1'b1, 1'b1, 1'b0, nv);
    check("stall_nvalid", 32'(nv), 32'd12);

    // Configuration errors
    do_start(2, 4, 1, 1'b1);
    check("err_w2_pulse", 32'(cfg_err), 32'd1);
    check("err_w2_busy", 32'(busy), 32'd0);
    tick();
    check("err_w2_one_cycle", 32'(cfg_err), 32'd0);
    do_start(4, 4, 0, 1'b1);
    check("err_c0_pulse", 32'(cfg_err), 32'd1);
    check("err_c0_busy", 32'(busy), 32'd0);
    do_start(4, 2, 1, 1'b1);
    check("err_h2_pulse", 32'(cfg_err), 32'd1);
    tick();
    check("err_idle_busy", 32'(busy), 32'd0);
    valid_i = 1'b1;
    tick();
    check("idle_ignores_valid", 32'(valid_o), 32'd0);
    valid_i = 1'b0;

    // Start while busy is ignored; layer continues with original cfg
    run_layer(4, 3, 1, 1'b1, 1'b0, 1'b1, nv);
    check("poke_nvalid", 32'(nv), 32'd12);

    // Wide image: 224x3, 1 channel
    run_layer(224, 3, 1, 1'b1, 1'b0, 1'b0, nv);
    check("wide_nvalid", 32'(nv), 32'd672);
    check("wide_last_y", 32'(y_o), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
